// File: rtl/csr_access_unit.sv
// CSR read-modify-write sequencer: IDLE -> READ -> WRITE -> DONE for legal requests, IDLE -> DONE for rejected ones.
// Optional write counter on perf_count is built when CSR_ACCESS_PERF_EN is defined.
module csr_access_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  funct3,
  input  logic [11:0] csr_index,
  input  logic [4:0]  rs1_index,
  input  logic [31:0] rs1_data,
  input  logic [4:0]  rd_index,
  input  logic [31:0] csr_read_data,
  output logic        read_enable_csr,
  output logic        write_enable_csr,
  output logic [11:0] csr_read_index,
  output logic [11:0] csr_write_index,
  output logic [31:0] csr_write_data,
  output logic [31:0] rd_write_data,
  output logic        rd_write_enable,
  output logic        busy,
  output logic        done,
  output logic        illegal,
  output logic [31:0] perf_count
);
  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_e;

  state_e      state_q, state_d;
  logic [2:0]  f3_q, f3_d;
  logic [11:0] csr_idx_q, csr_idx_d;
  logic [4:0]  rs1_idx_q, rs1_idx_d;
  logic [31:0] rs1_data_q, rs1_data_d;
  logic [4:0]  rd_idx_q, rd_idx_d;
  logic [31:0] old_q, old_d;
  logic [31:0] wdata_q, wdata_d;
  logic        rd_do_q, rd_do_d;
  logic        wr_do_q, wr_do_d;
  logic        rden_q, rden_d;
  logic        wren_q, wren_d;
  logic        rdwe_q, rdwe_d;
  logic        done_q, done_d;
  logic        ill_q, ill_d;

  logic        rd_sup_in, wr_sup_in, ill_in;
  logic [31:0] src, rd_val, new_val;

  // Suppression and legality are decided from the live request while in IDLE
  always_comb begin
    rd_sup_in = (funct3[1:0] == 2'b01) && (rd_index == 5'd0);
    wr_sup_in = (funct3[1:0] != 2'b01) && (rs1_index == 5'd0);
    ill_in    = (funct3[1:0] == 2'b00) || ((csr_index[11:10] == 2'b11) && !wr_sup_in);
  end

  always_comb begin
    src    = f3_q[2] ? {27'b0, rs1_idx_q} : rs1_data_q;
    rd_val = rd_do_q ? csr_read_data : 32'b0;
    case (f3_q[1:0])
      2'b10:   new_val = rd_val | src;
      2'b11:   new_val = rd_val & ~src;
      default: new_val = src;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    f3_d       = f3_q;
    csr_idx_d  = csr_idx_q;
    rs1_idx_d  = rs1_idx_q;
    rs1_data_d = rs1_data_q;
    rd_idx_d   = rd_idx_q;
    old_d      = old_q;
    wdata_d    = wdata_q;
    rd_do_d    = rd_do_q;
    wr_do_d    = wr_do_q;
    ill_d      = ill_q;
    rden_d     = 1'b0;
    wren_d     = 1'b0;
    rdwe_d     = 1'b0;
    done_d     = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        f3_d       = funct3;
        csr_idx_d  = csr_index;
        rs1_idx_d  = rs1_index;
        rs1_data_d = rs1_data;
        rd_idx_d   = rd_index;
        old_d      = 32'b0;
        ill_d      = ill_in;
        rd_do_d    = !ill_in && !rd_sup_in;
        wr_do_d    = !ill_in && !wr_sup_in;
        if (ill_in) begin
          state_d = DONE;
          done_d  = 1'b1;
        end else begin
          state_d = READ;
          rden_d  = !rd_sup_in;
        end
      end
      READ: begin
        old_d   = rd_val;
        wdata_d = new_val;
        wren_d  = wr_do_q;
        state_d = WRITE;
      end
      WRITE: begin
        done_d  = 1'b1;
        rdwe_d  = rd_do_q && (rd_idx_q != 5'd0);
        state_d = DONE;
      end
      default: begin
        ill_d   = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      f3_q       <= '0;
      csr_idx_q  <= '0;
      rs1_idx_q  <= '0;
      rs1_data_q <= '0;
      rd_idx_q   <= '0;
      old_q      <= '0;
      wdata_q    <= '0;
      rd_do_q    <= 1'b0;
      wr_do_q    <= 1'b0;
      rden_q     <= 1'b0;
      wren_q     <= 1'b0;
      rdwe_q     <= 1'b0;
      done_q     <= 1'b0;
      ill_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      f3_q       <= f3_d;
      csr_idx_q  <= csr_idx_d;
      rs1_idx_q  <= rs1_idx_d;
      rs1_data_q <= rs1_data_d;
      rd_idx_q   <= rd_idx_d;
      old_q      <= old_d;
      wdata_q    <= wdata_d;
      rd_do_q    <= rd_do_d;
      wr_do_q    <= wr_do_d;
      rden_q     <= rden_d;
      wren_q     <= wren_d;
      rdwe_q     <= rdwe_d;
      done_q     <= done_d;
      ill_q      <= ill_d;
    end
  end

  assign read_enable_csr  = rden_q;
  assign write_enable_csr = wren_q;
  assign csr_read_index   = csr_idx_q;
  assign csr_write_index  = csr_idx_q;
  assign csr_write_data   = wdata_q;
  assign rd_write_data    = old_q;
  assign rd_write_enable  = rdwe_q;
  assign busy             = (state_q != IDLE);
  assign done             = done_q;
  assign illegal          = ill_q;

`ifdef CSR_ACCESS_PERF_EN
  logic [31:0] perf_q, perf_d;

  always_comb begin
    perf_d = perf_q;
    if (state_q == DONE && !ill_q && wr_do_q) perf_d = perf_q + 32'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) perf_q <= '0;
    else        perf_q <= perf_d;
  end

  assign perf_count = perf_q;
`else
  assign perf_count = 32'b0;
`endif
endmodule

// File: tb/tb_csr_access_unit.sv
// Scoreboard bench for csr_access_unit: expected transactions are queued at issue and retired on done.
module tb_csr_access_unit;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  funct3 = '0;
  logic [11:0] csr_index = '0;
  logic [4:0]  rs1_index = '0;
  logic [31:0] rs1_data = '0;
  logic [4:0]  rd_index = '0;
  logic [31:0] csr_read_data = '0;
  logic        read_enable_csr, write_enable_csr, rd_write_enable, busy, done, illegal;
  logic [11:0] csr_read_index, csr_write_index;
  logic [31:0] csr_write_data, rd_write_data, perf_count;

  int errors = 0;
  int checks = 0;

  typedef struct {
    int          rd_cyc;
    int          wr_cyc;
    int          done_cyc;
    logic [31:0] wdata;
    logic [31:0] rd_data;
    logic        ill;
    logic        rd_we;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  csr_access_unit dut (
    .clk(clk), .reset(reset), .start(start), .funct3(funct3), .csr_index(csr_index),
    .rs1_index(rs1_index), .rs1_data(rs1_data), .rd_index(rd_index), .csr_read_data(csr_read_data),
    .read_enable_csr(read_enable_csr), .write_enable_csr(write_enable_csr),
    .csr_read_index(csr_read_index), .csr_write_index(csr_write_index),
    .csr_write_data(csr_write_data), .rd_write_data(rd_write_data),
    .rd_write_enable(rd_write_enable), .busy(busy), .done(done), .illegal(illegal),
    .perf_count(perf_count)
  );

  function automatic exp_t model(input logic [2:0] f3, input logic [11:0] csr, input logic [4:0] rs1i,
                                 input logic [31:0] rs1d, input logic [4:0] rd, input logic [31:0] rdata);
    exp_t e;
    logic rsup, wsup;
    logic [31:0] s, o;
    rsup = (f3 == 3'b001 || f3 == 3'b101) && rd == 0;
    wsup = !(f3 == 3'b001 || f3 == 3'b101) && rs1i == 0;
    e.ill = (f3 == 3'b000 || f3 == 3'b100) || (csr >= 12'hC00 && !wsup);
    e.rd_we = 1'b0; e.rd_cyc = 0; e.wr_cyc = 0; e.wdata = '0; e.rd_data = '0;
    if (e.ill) begin
      e.done_cyc = 1;
    end else begin
      e.done_cyc = 3;
      o = rsup ? 32'h0 : rdata;
      s = (f3 >= 3'd5) ? 32'(rs1i) : rs1d;
      if (f3 == 3'b001 || f3 == 3'b101)      e.wdata = s;
      else if (f3 == 3'b010 || f3 == 3'b110) e.wdata = o | s;
      else                                   e.wdata = o & ~s;
      e.rd_cyc  = rsup ? 0 : 1;
      e.wr_cyc  = wsup ? 0 : 2;
      e.rd_data = o;
      e.rd_we   = !rsup && rd != 0;
    end
    return e;
  endfunction

  task automatic do_op(input string nm, input logic [2:0] f3, input logic [11:0] csr, input logic [4:0] rs1i,
                       input logic [31:0] rs1d, input logic [4:0] rd, input logic [31:0] rdata, input exp_t e);
    int rc, wc, dc;
    logic [31:0] wd, rdd;
    logic il, rwe, idx_ok;
    exp_t x;
    rc = 0; wc = 0; dc = 0; wd = '0; rdd = '0; il = 1'b0; rwe = 1'b0; idx_ok = 1'b1;
    @(posedge clk); #1;
    funct3 = f3; csr_index = csr; rs1_index = rs1i; rs1_data = rs1d; rd_index = rd; csr_read_data = rdata;
    start = 1'b1;
    sb.push_back(e);
    @(posedge clk); #1;
    start = 1'b0;
    funct3 = '0; rs1_data = '0; rs1_index = '0; rd_index = '0; csr_index = '0;
    for (int cyc = 1; cyc <= 8; cyc++) begin
      @(negedge clk);
      if (read_enable_csr) begin rc = cyc; if (csr_read_index !== csr) idx_ok = 1'b0; end
      if (write_enable_csr) begin wc = cyc; wd = csr_write_data; if (csr_write_index !== csr) idx_ok = 1'b0; end
      if (done) begin dc = cyc; il = illegal; rwe = rd_write_enable; rdd = rd_write_data; break; end
    end
    x = sb.pop_front();
    checks++; if (dc !== x.done_cyc) begin errors++; $display("FAIL %s done_cycle got=%0d exp=%0d", nm, dc, x.done_cyc); end
    checks++; if (il !== x.ill) begin errors++; $display("FAIL %s illegal got=%b exp=%b", nm, il, x.ill); end
    checks++; if (rc !== x.rd_cyc) begin errors++; $display("FAIL %s read_cycle got=%0d exp=%0d", nm, rc, x.rd_cyc); end
    checks++; if (wc !== x.wr_cyc) begin errors++; $display("FAIL %s write_cycle got=%0d exp=%0d", nm, wc, x.wr_cyc); end
    checks++; if (rwe !== x.rd_we) begin errors++; $display("FAIL %s rd_we got=%b exp=%b", nm, rwe, x.rd_we); end
    checks++; if (!idx_ok) begin errors++; $display("FAIL %s csr_index got=mismatch exp=%h", nm, csr); end
    if (x.wr_cyc != 0) begin
      checks++; if (wd !== x.wdata) begin errors++; $display("FAIL %s wdata got=%h exp=%h", nm, wd, x.wdata); end
    end
    if (!x.ill) begin
      checks++; if (rdd !== x.rd_data) begin errors++; $display("FAIL %s rd_data got=%h exp=%h", nm, rdd, x.rd_data); end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    #12;
    checks++;
    if ({read_enable_csr, write_enable_csr, rd_write_enable, busy, done, illegal} !== 6'b0 ||
        csr_write_data !== 32'h0 || rd_write_data !== 32'h0 || csr_read_index !== 12'h0 ||
        csr_write_index !== 12'h0 || perf_count !== 32'h0) begin
      errors++; $display("FAIL reset outputs got=nonzero exp=all zero");
    end
    @(negedge clk); reset = 1'b1;
  endtask

  task automatic test_vectors();
    exp_t e;
    e = '{1, 2, 3, 32'h0000_00FF, 32'h0000_000F, 1'b0, 1'b1};
    do_op("csrrs", 3'b010, 12'h800, 5'd5, 32'h0000_00F0, 5'd3, 32'h0000_000F, e);
    e = '{0, 2, 3, 32'hDEAD_BEEF, 32'h0, 1'b0, 1'b0};
    do_op("csrrw_rd0", 3'b001, 12'h340, 5'd7, 32'hDEAD_BEEF, 5'd0, 32'h5555_AAAA, e);
    e = '{1, 0, 3, 32'h0, 32'h1234_5678, 1'b0, 1'b1};
    do_op("csrrci_rs0", 3'b111, 12'h300, 5'd0, 32'hFFFF_FFFF, 5'd1, 32'h1234_5678, e);
    e = '{0, 0, 1, 32'h0, 32'h0, 1'b1, 1'b0};
    do_op("funct3_100", 3'b100, 12'h300, 5'd3, 32'h1, 5'd2, 32'h1, e);
    do_op("ro_write", 3'b001, 12'hC00, 5'd3, 32'h1, 5'd2, 32'h1, e);
    e = '{1, 0, 3, 32'h0, 32'hCAFE_0001, 1'b0, 1'b1};
    do_op("ro_read_rs", 3'b010, 12'hC01, 5'd0, 32'h1, 5'd4, 32'hCAFE_0001, e);
    e = '{1, 2, 3, 32'hF0F0_F0E0, 32'hF0F0_F0FF, 1'b0, 1'b1};
    do_op("csrrci", 3'b111, 12'h305, 5'd31, 32'h0, 5'd9, 32'hF0F0_F0FF, e);
  endtask

  task automatic test_random();
    logic [2:0] f3; logic [11:0] csr; logic [4:0] r1, rd; logic [31:0] d, rdat;
    for (int i = 0; i < 10; i++) begin
      f3 = 3'($urandom_range(0, 7));
      csr = {2'($urandom_range(0, 3)), 10'($urandom)};
      r1 = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
      rd = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
      d = $urandom; rdat = $urandom;
      do_op($sformatf("rand%0d", i), f3, csr, r1, d, rd, rdat, model(f3, csr, r1, d, rd, rdat));
    end
  endtask

  task automatic test_reset_abort();
    logic bad;
    bad = 1'b0;
    @(posedge clk); #1;
    funct3 = 3'b001; csr_index = 12'h340; rs1_index = 5'd1; rs1_data = 32'h0BAD_F00D; rd_index = 5'd1;
    start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++; if (write_enable_csr !== 1'b1) begin errors++; $display("FAIL abort_pre wren got=%b exp=1", write_enable_csr); end
    #1 reset = 1'b0;
    #1;
    checks++; if (write_enable_csr !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL abort_async wren/busy got=%b%b exp=00", write_enable_csr, busy);
    end
    @(negedge clk); reset = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (done || write_enable_csr || busy) bad = 1'b1;
    end
    checks++; if (bad) begin errors++; $display("FAIL abort_after got=activity exp=idle"); end
  endtask

  task automatic test_back_to_back();
    int rd_cycs[$]; int nreads, ndone;
    exp_t e;
    nreads = 0; ndone = 0;
    sb.push_back('{1, 2, 3, 32'h0000_0033, 32'h0000_0011, 1'b0, 1'b1});
    sb.push_back('{5, 6, 7, 32'h0000_0033, 32'h0000_0011, 1'b0, 1'b1});
    @(posedge clk); #1;
    funct3 = 3'b010; csr_index = 12'h7C0; rs1_index = 5'd2; rs1_data = 32'h22; rd_index = 5'd6;
    csr_read_data = 32'h11;
    start = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (read_enable_csr) begin nreads++; rd_cycs.push_back(c); end
      if (done) begin
        ndone++;
        e = sb.pop_front();
        checks++; if (c !== e.done_cyc) begin errors++; $display("FAIL b2b done_cycle got=%0d exp=%0d", c, e.done_cyc); end
        checks++; if (rd_write_data !== e.rd_data || rd_write_enable !== e.rd_we) begin
          errors++; $display("FAIL b2b rd got=%h/%b exp=%h/%b", rd_write_data, rd_write_enable, e.rd_data, e.rd_we);
        end
        if (sb.size() == 0) break;
      end
      if (write_enable_csr) begin
        checks++; if (csr_write_data !== 32'h33) begin errors++; $display("FAIL b2b wdata got=%h exp=00000033", csr_write_data); end
      end
      @(posedge clk); #1;
      if (c == 4) start = 1'b0;
    end
    start = 1'b0;
    checks++; if (nreads !== 2 || ndone !== 2) begin errors++; $display("FAIL b2b counts got=%0d/%0d exp=2/2", nreads, ndone); end
    checks++; if (rd_cycs.size() < 2 || rd_cycs[1] !== 5) begin errors++; $display("FAIL b2b second_read got=other exp=cycle 5"); end
    sb.delete();
  endtask

  task automatic test_perf();
    exp_t e;
`ifdef CSR_ACCESS_PERF_EN
    force dut.perf_q = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    release dut.perf_q;
    checks++; if (perf_count !== 32'hFFFF_FFFF) begin errors++; $display("FAIL perf_preload got=%h exp=ffffffff", perf_count); end
`endif
    e = '{0, 2, 3, 32'h0000_0042, 32'h0, 1'b0, 1'b0};
    do_op("perf_wr", 3'b001, 12'h341, 5'd3, 32'h42, 5'd0, 32'h0, e);
    @(posedge clk); #1;
    checks++; if (perf_count !== 32'h0) begin errors++; $display("FAIL perf_wrap got=%h exp=00000000", perf_count); end
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_random();
    test_reset_abort();
    test_back_to_back();
    test_perf();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end
endmodule
